// File: rtl/ram_sp_burst_reader_pkg.sv
// Shared types and helpers for the RAM burst reader: FSM state encoding
// and the read-issue credit rule.
package ram_sp_burst_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // A read may issue only if every word already owed to the stream still fits in the FIFO.
    function automatic logic credit_ok(input logic [1:0] fifo_count,
                                       input logic       in_flight,
                                       input logic       pop);
        return ({1'b0, fifo_count} + {2'b0, in_flight}) < (3'(FIFO_DEPTH) + {2'b0, pop});
    endfunction

endpackage

// File: rtl/ram_sp_burst_reader_sync_fifo2.sv
// Two-entry synchronous FIFO with push/pop/count; head is visible on data_o
// whenever valid_o is high.
module sync_fifo2 #(
    parameter int WIDTH = 9
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             push_ok;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != 2'd0);
    assign push_ok = push_i && ((count_q != 2'd2) || pop_ok);
    assign count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ram_sp_burst_reader.sv
// Burst read initiator for ram_sp: walks base..base+length-1 and streams the
// words out over valid/ready, absorbing the one-cycle RAM read latency.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; done pulse may be showing
// ST_READ  | address on the bus is the next word to fetch
// ST_DRAIN | all reads issued; waiting for the last beat (or zero length)
module ram_sp_burst_reader
    import ram_sp_burst_reader_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 12,
    parameter int LWIDTH = 13
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [AWIDTH-1:0] base_addr_i,
    input  logic [LWIDTH-1:0] length_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_wren_o,
    output logic [AWIDTH-1:0] mem_address_o,
    input  logic [DWIDTH-1:0] mem_q_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_data_o,
    output logic              out_last_o
);

    state_e            state_q;
    logic [AWIDTH-1:0] addr_q;
    logic [LWIDTH-1:0] remaining_q;
    logic              rd_valid_q;
    logic              rd_last_q;
    logic              len_zero_q;
    logic              busy_q;
    logic              done_q;

    logic [DWIDTH:0]   fifo_head;
    logic [1:0]        fifo_count;
    logic              fifo_valid;
    logic              pop;
    logic              issue;

    assign pop   = fifo_valid && out_ready_i;
    assign issue = (state_q == ST_READ) && credit_ok(fifo_count, rd_valid_q, pop);

    // rd_valid_q marks that mem_q_i carries a word sampled at the previous edge.
    sync_fifo2 #(
        .WIDTH (DWIDTH + 1)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .push_i  (rd_valid_q),
        .data_i  ({rd_last_q, mem_q_i}),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .valid_o (fifo_valid),
        .count_o (fifo_count)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            len_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            rd_valid_q <= issue;
            rd_last_q  <= issue && (remaining_q == LWIDTH'(1));
            if (done_q) begin
                busy_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        busy_q <= 1'b1;
                        if (length_i != '0) begin
                            addr_q      <= base_addr_i;
                            remaining_q <= length_i;
                            len_zero_q  <= 1'b0;
                            state_q     <= ST_READ;
                        end else begin
                            len_zero_q  <= 1'b1;
                            state_q     <= ST_DRAIN;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q      <= addr_q + AWIDTH'(1);
                        remaining_q <= remaining_q - LWIDTH'(1);
                        if (remaining_q == LWIDTH'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (len_zero_q || (pop && fifo_head[DWIDTH])) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign mem_wren_o    = 1'b0;
    assign mem_address_o = addr_q;
    assign out_valid_o   = fifo_valid;
    assign out_data_o    = fifo_head[DWIDTH-1:0];
    assign out_last_o    = fifo_head[DWIDTH];

endmodule

// File: tb/tb_ram_sp_burst_reader.sv
// Self-checking bench for ram_sp_burst_reader; a behavioural RAM returns
// mem[a] = a[7:0] one cycle after the address is sampled.
module tb_ram_sp_burst_reader;

    localparam int DW = 8;
    localparam int AW = 12;
    localparam int LW = 13;
    localparam int AMOD = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base = '0;
    logic [LW-1:0] len = '0;
    logic          busy;
    logic          done;
    logic          wren;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mq = '0;
    logic          valid;
    logic          ready = 1'b0;
    logic [DW-1:0] data;
    logic          last;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int e0 = 0;

    int got_data[$];
    int got_last[$];
    int got_cyc[$];
    int done_cycs[$];
    int addr_trace[$];
    int first_valid_cyc;
    int busy_cycles;
    int busy_after_done;
    int stall_viol;
    int wren_viol = 0;
    int stall_addr;
    int stall_valid;
    int stall_data;

    ram_sp_burst_reader #(.DWIDTH(DW), .AWIDTH(AW), .LWIDTH(LW)) dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .start_i       (start),
        .base_addr_i   (base),
        .length_i      (len),
        .busy_o        (busy),
        .done_o        (done),
        .mem_wren_o    (wren),
        .mem_address_o (maddr),
        .mem_q_i       (mq),
        .out_valid_o   (valid),
        .out_ready_i   (ready),
        .out_data_o    (data),
        .out_last_o    (last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mq <= maddr[7:0];

    function automatic int exp_byte(input int b, input int i);
        return ((b + i) % AMOD) % 256;
    endfunction

    task automatic pulse_start(input int b, input int l);
        start = 1'b1;
        base  = AW'(b);
        len   = LW'(l);
        @(posedge clk);
        #1;
        e0    = cyc;
        start = 1'b0;
    endtask

    // mode: 0 ready=1, 1 toggling, 2 random, 3 held 0 for 20 cycles
    task automatic capture(input int mode, input int max_cyc, input int inject_at, input int stop_beats);
        bit prev_stall = 1'b0;
        int prev_data = 0;
        int prev_last = 0;
        bit done_seen = 1'b0;
        bit finished = 1'b0;
        got_data.delete(); got_last.delete(); got_cyc.delete();
        done_cycs.delete(); addr_trace.delete();
        first_valid_cyc = -1; busy_cycles = 0; busy_after_done = -1; stall_viol = 0;
        stall_addr = -1; stall_valid = -1; stall_data = -1;
        for (int n = 0; n < max_cyc; n++) begin
            case (mode)
                0: ready = 1'b1;
                1: ready = (n % 2 == 0);
                2: ready = 1'($urandom_range(0, 1));
                default: ready = (n >= 20);
            endcase
            if (n == inject_at) begin
                start = 1'b1;
                base  = AW'($urandom);
                len   = LW'(3);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (wren !== 1'b0) wren_viol++;
            if (busy === 1'b1) busy_cycles++;
            if (addr_trace.size() == 0 || addr_trace[$] != int'(maddr)) addr_trace.push_back(int'(maddr));
            if (valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall && !(valid === 1'b1 && int'(data) == prev_data && int'(last) == prev_last))
                stall_viol++;
            prev_stall = (valid === 1'b1 && ready === 1'b0);
            prev_data  = int'(data);
            prev_last  = int'(last);
            if (n == 19) begin
                stall_addr  = int'(maddr);
                stall_valid = int'(valid);
                stall_data  = int'(data);
            end
            if (valid === 1'b1 && ready === 1'b1) begin
                got_data.push_back(int'(data));
                got_last.push_back(int'(last));
                got_cyc.push_back(cyc);
            end
            if (done_seen) begin
                busy_after_done = int'(busy);
                finished = 1'b1;
            end
            if (done === 1'b1) begin
                done_cycs.push_back(cyc);
                done_seen = 1'b1;
            end
            @(posedge clk);
            #1;
            if (finished || (stop_beats > 0 && got_data.size() >= stop_beats)) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (maddr !== '0) begin failures++; $display("FAIL reset_addr got=%0d want=0", maddr); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b want=0", last); end
        checks++; if (data !== '0) begin failures++; $display("FAIL reset_data got=%0h want=0", data); end
        checks++; if (wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b want=0", wren); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        pulse_start(0, 4);
        capture(0, 60, -1, 0);
        checks++; if (addr_trace[0] != 0) begin failures++; $display("FAIL basic_addr0 got=%0d want=0", addr_trace[0]); end
        checks++; if (first_valid_cyc != e0 + 2) begin failures++; $display("FAIL basic_latency got=%0d want=%0d", first_valid_cyc, e0 + 2); end
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL basic_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if (got_data[i] != exp_byte(0, i) || got_last[i] != int'(i == 3)) begin
                failures++; $display("FAIL basic_beat%0d got=%0h/%0d want=%0h/%0d", i, got_data[i], got_last[i], exp_byte(0, i), int'(i == 3));
            end
        end
        if (got_cyc.size() == 4) begin
            checks++; if (got_cyc[3] - got_cyc[0] != 3) begin failures++; $display("FAIL basic_throughput got=%0d want=3", got_cyc[3] - got_cyc[0]); end
        end
        checks++;
        if (done_cycs.size() != 1 || got_cyc.size() == 0 || done_cycs[0] != got_cyc[$] + 1) begin
            failures++; $display("FAIL basic_done ndone=%0d want 1 pulse one cycle after last beat", done_cycs.size());
        end
        checks++; if (busy_after_done != 0) begin failures++; $display("FAIL basic_busy_drop got=%0d want=0", busy_after_done); end
    endtask

    task automatic test_backpressure;
        pulse_start(16, 8);
        capture(1, 100, -1, 0);
        checks++; if (got_data.size() != 8) begin failures++; $display("FAIL bp_count got=%0d want=8", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 8; i++) begin
            checks++;
            if (got_data[i] != exp_byte(16, i) || got_last[i] != int'(i == 7)) begin
                failures++; $display("FAIL bp_beat%0d got=%0h/%0d want=%0h/%0d", i, got_data[i], got_last[i], exp_byte(16, i), int'(i == 7));
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL bp_stable got=%0d want=0 violations", stall_viol); end
        checks++; if (done_cycs.size() != 1) begin failures++; $display("FAIL bp_done got=%0d want=1", done_cycs.size()); end
    endtask

    task automatic test_wrap;
        int exp_addr[4] = '{4094, 4095, 0, 1};
        pulse_start(4094, 4);
        capture(0, 60, -1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (addr_trace.size() <= i || addr_trace[i] != exp_addr[i]) begin
                failures++; $display("FAIL wrap_addr%0d got=%0d want=%0d", i, (addr_trace.size() > i) ? addr_trace[i] : -1, exp_addr[i]);
            end
        end
        checks++; if (got_data.size() != 4) begin failures++; $display("FAIL wrap_count got=%0d want=4", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 4; i++) begin
            checks++;
            if (got_data[i] != exp_byte(4094, i) || got_last[i] != int'(i == 3)) begin
                failures++; $display("FAIL wrap_beat%0d got=%0h/%0d want=%0h/%0d", i, got_data[i], got_last[i], exp_byte(4094, i), int'(i == 3));
            end
        end
    endtask

    task automatic test_zero_length;
        pulse_start(123, 0);
        capture(0, 20, -1, 0);
        checks++; if (first_valid_cyc >= 0) begin failures++; $display("FAIL zero_valid got=high want=never"); end
        checks++;
        if (done_cycs.size() != 1 || done_cycs[0] != e0 + 1) begin
            failures++; $display("FAIL zero_done ndone=%0d at=%0d want 1 at %0d", done_cycs.size(), (done_cycs.size() > 0) ? done_cycs[0] : -1, e0 + 1);
        end
        checks++; if (busy_cycles != 2) begin failures++; $display("FAIL zero_busy got=%0d want=2", busy_cycles); end
    endtask

    task automatic test_ignore_and_reset;
        pulse_start(0, 6);
        capture(0, 60, 2, 0);
        checks++; if (got_data.size() != 6) begin failures++; $display("FAIL ign_count got=%0d want=6", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 6; i++) begin
            checks++;
            if (got_data[i] != exp_byte(0, i)) begin failures++; $display("FAIL ign_beat%0d got=%0h want=%0h", i, got_data[i], exp_byte(0, i)); end
        end
        checks++; if (done_cycs.size() != 1) begin failures++; $display("FAIL ign_done got=%0d want=1", done_cycs.size()); end

        pulse_start(0, 6);
        capture(0, 60, -1, 2);
        ready = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
        @(posedge clk);
        #1;
        capture(0, 12, -1, 0);
        checks++; if (done_cycs.size() != 0 || got_data.size() != 0) begin
            failures++; $display("FAIL rst_quiet done=%0d beats=%0d want=0/0", done_cycs.size(), got_data.size());
        end

        pulse_start(8, 2);
        capture(0, 40, -1, 0);
        checks++;
        if (got_data.size() != 2 || got_data[0] != 8 || got_data[1] != 9 || got_last[0] != 0 || got_last[1] != 1) begin
            failures++; $display("FAIL rst_next beats=%0d want 08,09 with last on 09", got_data.size());
        end
        checks++; if (done_cycs.size() != 1) begin failures++; $display("FAIL rst_next_done got=%0d want=1", done_cycs.size()); end
    endtask

    task automatic test_stall;
        int b = int'($urandom_range(0, AMOD - 1));
        pulse_start(b, 5);
        capture(3, 100, -1, 0);
        checks++; if (stall_addr != (b + 2) % AMOD) begin failures++; $display("FAIL stall_outstanding addr=%0d want=%0d", stall_addr, (b + 2) % AMOD); end
        checks++; if (stall_valid != 1 || stall_data != exp_byte(b, 0)) begin
            failures++; $display("FAIL stall_head got=%0d/%0h want=1/%0h", stall_valid, stall_data, exp_byte(b, 0));
        end
        checks++; if (got_data.size() != 5) begin failures++; $display("FAIL stall_count got=%0d want=5", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 5; i++) begin
            checks++;
            if (got_data[i] != exp_byte(b, i) || got_last[i] != int'(i == 4)) begin
                failures++; $display("FAIL stall_beat%0d got=%0h/%0d want=%0h/%0d", i, got_data[i], got_last[i], exp_byte(b, i), int'(i == 4));
            end
        end
        checks++; if (stall_viol != 0) begin failures++; $display("FAIL stall_stable got=%0d want=0", stall_viol); end
    endtask

    task automatic test_random_bursts;
        for (int k = 0; k < 6; k++) begin
            int b = (k == 0) ? 4090 : int'($urandom_range(0, AMOD - 1));
            int l = int'($urandom_range(1, 12));
            pulse_start(b, l);
            capture(2, 400, -1, 0);
            checks++; if (got_data.size() != l) begin failures++; $display("FAIL rand%0d_count got=%0d want=%0d", k, got_data.size(), l); end
            for (int i = 0; i < got_data.size() && i < l; i++) begin
                checks++;
                if (got_data[i] != exp_byte(b, i) || got_last[i] != int'(i == l - 1)) begin
                    failures++; $display("FAIL rand%0d_beat%0d got=%0h/%0d want=%0h/%0d", k, i, got_data[i], got_last[i], exp_byte(b, i), int'(i == l - 1));
                end
            end
            checks++; if (done_cycs.size() != 1 || stall_viol != 0) begin
                failures++; $display("FAIL rand%0d_done ndone=%0d stallviol=%0d want=1/0", k, done_cycs.size(), stall_viol);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_ignore_and_reset();
        test_stall();
        test_random_bursts();
        checks++; if (wren_viol != 0) begin failures++; $display("FAIL wren_zero got=%0d cycles high want=0", wren_viol); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
